// File: rtl/output_tile_writer.sv
// output_tile_writer
//   Buffers packed 4x4 int8 tiles in a small FIFO and writes each tile into
//   activation memory as four 32-bit words, one per tile row.
//
// Ports
//   clk, reset      rising-edge clock; asynchronous active-high reset
//   in_valid        one-cycle pulse, tile present on in_data/in_row/in_col
//   in_data         packed tile (2x2 quadrant-major byte order, byte 0 at MSB)
//   in_row, in_col  tile origin in the feature map
//   words_per_row   32-bit words per feature-map row (static while busy)
//   base_addr       word address of map pixel (0,0) (static while busy)
//   mem_ready       memory accepts the presented write this cycle
//   mem_we          write request
//   mem_addr        word address of the write
//   mem_wdata       four pixels of one tile row, column 0 in the low byte
//   idle            FIFO empty and writer idle
//   overflow        sticky, a tile was dropped because the FIFO was full
//   misaligned      sticky, a tile arrived with in_col[1:0] != 0
//   tiles_written   count of completely written tiles (wraps)
module output_tile_writer #(
   parameter int MAX_N      = 64,
   parameter int N_BITS     = $clog2(MAX_N),
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [127:0]      in_data,
   input  logic [N_BITS-1:0] in_row,
   input  logic [N_BITS-1:0] in_col,
   input  logic [ADDR_W-1:0] words_per_row,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              idle,
   output logic              overflow,
   output logic              misaligned,
   output logic [15:0]       tiles_written
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PROD_W = ADDR_W + N_BITS + 2;

   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   state_t            state;
   logic [1:0]        r;

   logic [127:0]      fifo_data_p0 [FIFO_DEPTH];
   logic [N_BITS-1:0] fifo_row_p0  [FIFO_DEPTH];
   logic [N_BITS-1:0] fifo_col_p0  [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr_nxt;
   logic [CNT_W-1:0]  count;

   logic              accept_wr;
   logic              pop;
   logic              full;
   logic              push;
   logic              has_next;

   logic [127:0]      sel_data;
   logic [N_BITS-1:0] sel_row;
   logic [N_BITS-1:0] sel_col;
   logic [1:0]        sel_r;
   logic [ADDR_W-1:0] nxt_addr_p0;
   logic [31:0]       nxt_wdata_p0;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // Row index gets two extra bits so origin + 3 never wraps at MAX_N;
   // the final sum is taken modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] calc_addr(
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] wpr,
      input logic [N_BITS-1:0] row,
      input logic [N_BITS-1:0] col,
      input logic [1:0]        rr
   );
      logic [N_BITS+1:0] row_sum;
      logic [PROD_W-1:0] prod;
      row_sum = {2'b00, row} + {{N_BITS{1'b0}}, rr};
      prod    = {{ADDR_W{1'b0}}, row_sum} * {{(N_BITS+2){1'b0}}, wpr};
      return base + prod[ADDR_W-1:0] + ADDR_W'(col >> 2);
   endfunction

   // Tile bytes are stored quadrant-major: byte k = 4*chunk + within, with
   // chunk selecting the 2x2 quadrant and within the pixel inside it.
   // Pixels are int8 but only moved, never altered.
   function automatic logic [31:0] row_word(input logic [127:0] tile,
                                            input logic [1:0]   rr);
      logic [31:0]       w;
      logic signed [7:0] pix;
      int                k;
      w = '0;
      for (int c = 0; c < 4; c++) begin
         k   = 8 * int'(rr[1]) + 4 * (c >> 1) + 2 * int'(rr[0]) + (c & 1);
         pix = tile[127 - 8*k -: 8];
         w[8*c +: 8] = pix;
      end
      return w;
   endfunction

   // A full FIFO still accepts a push when the head is retired the same cycle.
   assign accept_wr  = mem_we & mem_ready;
   assign pop        = accept_wr & (r == 2'd3);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign push       = in_valid & (~full | pop);
   assign has_next   = (count > CNT_W'(1)) | push;
   assign rd_ptr_nxt = ptr_inc(rd_ptr);
   assign idle       = (state == ST_IDLE) && (count == '0);

   // Stage p0: FIFO storage, data only
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_p0[wr_ptr] <= in_data;
         fifo_row_p0[wr_ptr]  <= in_row;
         fifo_col_p0[wr_ptr]  <= in_col;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= rd_ptr_nxt;
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Choose which entry/row the next presented write refers to. After the
   // last row of a tile the next tile comes from the entry behind the head,
   // or straight from the input when it is being pushed this very cycle.
   always_comb begin
      sel_data = fifo_data_p0[rd_ptr];
      sel_row  = fifo_row_p0[rd_ptr];
      sel_col  = fifo_col_p0[rd_ptr];
      sel_r    = r + 2'd1;
      if (state == ST_IDLE) begin
         sel_r = 2'd0;
      end else if (r == 2'd3) begin
         sel_r = 2'd0;
         if (count > CNT_W'(1)) begin
            sel_data = fifo_data_p0[rd_ptr_nxt];
            sel_row  = fifo_row_p0[rd_ptr_nxt];
            sel_col  = fifo_col_p0[rd_ptr_nxt];
         end else begin
            sel_data = in_data;
            sel_row  = in_row;
            sel_col  = in_col;
         end
      end
   end

   assign nxt_addr_p0  = calc_addr(base_addr, words_per_row, sel_row, sel_col, sel_r);
   assign nxt_wdata_p0 = row_word(sel_data, sel_r);

   // Stage p1: registered write port and status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         r             <= 2'd0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         overflow      <= 1'b0;
         misaligned    <= 1'b0;
         tiles_written <= '0;
      end else begin
         if (in_valid && !push)                overflow   <= 1'b1;
         if (in_valid && (in_col[1:0] != 2'b00)) misaligned <= 1'b1;
         if (pop) tiles_written <= tiles_written + 16'd1;

         case (state)
            ST_IDLE: begin
               if (count != '0) begin
                  state     <= ST_WRITE;
                  r         <= 2'd0;
                  mem_we    <= 1'b1;
                  mem_addr  <= nxt_addr_p0;
                  mem_wdata <= nxt_wdata_p0;
               end
            end
            ST_WRITE: begin
               // Address/data only move on an accepted write, so they hold
               // through memory stalls.
               if (accept_wr) begin
                  if ((r == 2'd3) && !has_next) begin
                     state  <= ST_IDLE;
                     r      <= 2'd0;
                     mem_we <= 1'b0;
                  end else begin
                     r         <= sel_r;
                     mem_addr  <= nxt_addr_p0;
                     mem_wdata <= nxt_wdata_p0;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               mem_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_tile_writer.sv
module tb_output_tile_writer;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [127:0] in_data = '0;
   logic [5:0]   in_row = '0;
   logic [5:0]   in_col = '0;
   logic [15:0]  words_per_row = '0;
   logic [15:0]  base_addr = '0;
   logic         mem_ready = 1'b0;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         idle;
   logic         overflow;
   logic         misaligned;
   logic [15:0]  tiles_written;

   output_tile_writer #(
      .MAX_N(64), .N_BITS(6), .ADDR_W(16), .FIFO_DEPTH(2)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_row(in_row), .in_col(in_col), .words_per_row(words_per_row),
      .base_addr(base_addr), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .idle(idle),
      .overflow(overflow), .misaligned(misaligned), .tiles_written(tiles_written)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   int         n_checks = 0;
   int         n_bad = 0;
   int         n_writes = 0;
   logic [7:0] pix [16];

   // Scoreboard: every accepted write must match the oldest expected write.
   always @(negedge clk) begin
      if (!reset && mem_we && mem_ready) begin
         n_writes++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write got addr=%h data=%h, none expected", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
               n_bad++;
               $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                        mem_addr, mem_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   // Build the packed tile from pixel (R,C) values.
   function automatic logic [127:0] pack_tile();
      logic [127:0] d;
      int k;
      d = '0;
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++) begin
            k = 4 * (2 * (rr / 2) + (cc / 2)) + 2 * (rr % 2) + (cc % 2);
            d[127 - 8*k -: 8] = pix[4*rr + cc];
         end
      return d;
   endfunction

   task automatic rand_tile();
      for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
   endtask

   task automatic expect_tile(input int row, input int col);
      wr_t e;
      for (int rr = 0; rr < 4; rr++) begin
         e.addr = 16'(int'(base_addr) + (row + rr) * int'(words_per_row) + col / 4);
         e.data = {pix[4*rr+3], pix[4*rr+2], pix[4*rr+1], pix[4*rr]};
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse(input int row, input int col, input logic [127:0] d);
      in_valid = 1'b1;
      in_row   = 6'(row);
      in_col   = 6'(col);
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (idle && !mem_we && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_addr(input logic [15:0] a, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (mem_we && mem_addr == a) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      #2;
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_port got we=%b addr=%h data=%h exp 0/0/0", mem_we, mem_addr, mem_wdata);
      end
      n_checks++;
      if (idle !== 1'b1 || overflow !== 1'b0 || misaligned !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_status got idle=%b ovf=%b mis=%b exp 1/0/0", idle, overflow, misaligned);
      end
      n_checks++;
      if (tiles_written !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_count got %0d exp 0", tiles_written);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (idle !== 1'b1 || mem_we !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release got idle=%b we=%b exp 1/0", idle, mem_we);
      end
   endtask

   task automatic test_single();
      bit ok;
      int w0;
      wr_t e;
      apply_reset();
      base_addr = 16'h100; words_per_row = 16'd4; mem_ready = 1'b1;
      e.addr = 16'h109; e.data = 32'h05040100; exp_q.push_back(e);
      e.addr = 16'h10D; e.data = 32'h07060302; exp_q.push_back(e);
      e.addr = 16'h111; e.data = 32'h0D0C0908; exp_q.push_back(e);
      e.addr = 16'h115; e.data = 32'h0F0E0B0A; exp_q.push_back(e);
      w0 = n_writes;
      pulse(2, 4, 128'h000102030405060708090A0B0C0D0E0F);
      n_checks++;
      if (idle !== 1'b0 || mem_we !== 1'b0) begin
         n_bad++;
         $display("FAIL single_latency0 got idle=%b we=%b exp 0/0", idle, mem_we);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h109) begin
         n_bad++;
         $display("FAIL single_latency1 got we=%b addr=%h exp 1/0109", mem_we, mem_addr);
      end
      wait_done(50, ok);
      n_checks++;
      if (!ok) begin
         n_bad++;
         $display("FAIL single_timeout got pending=%0d exp 0", exp_q.size());
      end
      n_checks++;
      if (tiles_written !== 16'd1 || idle !== 1'b1 || n_writes - w0 != 4) begin
         n_bad++;
         $display("FAIL single_done got tiles=%0d idle=%b writes=%0d exp 1/1/4",
                  tiles_written, idle, n_writes - w0);
      end
   endtask

   task automatic test_stall();
      bit ok;
      int w0;
      wr_t e;
      apply_reset();
      base_addr = 16'h100; words_per_row = 16'd4; mem_ready = 1'b1;
      e.addr = 16'h109; e.data = 32'h05040100; exp_q.push_back(e);
      e.addr = 16'h10D; e.data = 32'h07060302; exp_q.push_back(e);
      e.addr = 16'h111; e.data = 32'h0D0C0908; exp_q.push_back(e);
      e.addr = 16'h115; e.data = 32'h0F0E0B0A; exp_q.push_back(e);
      w0 = n_writes;
      pulse(2, 4, 128'h000102030405060708090A0B0C0D0E0F);
      wait_addr(16'h10D, 20, ok);
      n_checks++;
      if (!ok) begin
         n_bad++;
         $display("FAIL stall_reach_r1 got addr=%h exp 010D", mem_addr);
      end
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (mem_we !== 1'b1 || mem_addr !== 16'h10D || mem_wdata !== 32'h07060302) begin
            n_bad++;
            $display("FAIL stall_hold got we=%b addr=%h data=%h exp 1/010D/07060302",
                     mem_we, mem_addr, mem_wdata);
         end
      end
      mem_ready = 1'b1;
      wait_done(50, ok);
      n_checks++;
      if (!ok || n_writes - w0 != 4 || tiles_written !== 16'd1) begin
         n_bad++;
         $display("FAIL stall_done got ok=%b writes=%0d tiles=%0d exp 1/4/1",
                  ok, n_writes - w0, tiles_written);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int gaps;
      logic [127:0] d;
      apply_reset();
      base_addr = 16'h0; words_per_row = 16'd16; mem_ready = 1'b1;
      rand_tile(); d = pack_tile(); expect_tile(0, 0); pulse(0, 0, d);
      rand_tile(); d = pack_tile(); expect_tile(4, 8); pulse(4, 8, d);
      gaps = 0;
      for (int i = 0; i < 8; i++) begin
         if (mem_we !== 1'b1) gaps++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (gaps != 0) begin
         n_bad++;
         $display("FAIL b2b_we_gap got %0d low cycles exp 0", gaps);
      end
      wait_done(20, ok);
      n_checks++;
      if (!ok || tiles_written !== 16'd2 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_done got ok=%b tiles=%0d ovf=%b exp 1/2/0", ok, tiles_written, overflow);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      logic [127:0] d;
      apply_reset();
      base_addr = 16'h0; words_per_row = 16'd16; mem_ready = 1'b0;
      rand_tile(); d = pack_tile(); expect_tile(0, 0); pulse(0, 0, d);
      rand_tile(); d = pack_tile(); expect_tile(4, 0); pulse(4, 0, d);
      rand_tile(); d = pack_tile(); pulse(8, 0, d);
      n_checks++;
      if (overflow !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_set got %b exp 1", overflow);
      end
      mem_ready = 1'b1;
      wait_done(60, ok);
      n_checks++;
      if (!ok || tiles_written !== 16'd2 || overflow !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_drain got ok=%b tiles=%0d ovf=%b exp 1/2/1", ok, tiles_written, overflow);
      end

      // Full FIFO, push lands on the cycle the head's last row is accepted.
      apply_reset();
      mem_ready = 1'b0;
      rand_tile(); d = pack_tile(); expect_tile(0, 0); pulse(0, 0, d);
      rand_tile(); d = pack_tile(); expect_tile(4, 0); pulse(4, 0, d);
      mem_ready = 1'b1;
      wait_addr(16'd48, 20, ok);
      n_checks++;
      if (!ok) begin
         n_bad++;
         $display("FAIL ovf_reach_r3 got addr=%h exp 0030", mem_addr);
      end
      rand_tile(); d = pack_tile(); expect_tile(8, 0); pulse(8, 0, d);
      n_checks++;
      if (overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_coincident got %b exp 0", overflow);
      end
      wait_done(60, ok);
      n_checks++;
      if (!ok || tiles_written !== 16'd3 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_coincident_done got ok=%b tiles=%0d ovf=%b exp 1/3/0",
                  ok, tiles_written, overflow);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [127:0] d;
      apply_reset();
      base_addr = 16'h0; words_per_row = 16'd16; mem_ready = 1'b1;
      rand_tile(); d = pack_tile(); expect_tile(0, 0); pulse(0, 0, d);
      wait_addr(16'd32, 20, ok);
      n_checks++;
      if (!ok) begin
         n_bad++;
         $display("FAIL rmid_reach_r2 got addr=%h exp 0020", mem_addr);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== 16'h0 || idle !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_async got we=%b addr=%h idle=%b exp 0/0000/1", mem_we, mem_addr, idle);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (idle !== 1'b1 || tiles_written !== 16'd0 || mem_we !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_release got idle=%b tiles=%0d we=%b exp 1/0/0", idle, tiles_written, mem_we);
      end
      rand_tile(); d = pack_tile(); expect_tile(1, 4); pulse(1, 4, d);
      @(posedge clk); #1;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 16'd17) begin
         n_bad++;
         $display("FAIL rmid_restart got we=%b addr=%h exp 1/0011", mem_we, mem_addr);
      end
      wait_done(30, ok);
      n_checks++;
      if (!ok || tiles_written !== 16'd1) begin
         n_bad++;
         $display("FAIL rmid_done got ok=%b tiles=%0d exp 1/1", ok, tiles_written);
      end
   endtask

   task automatic test_misaligned();
      bit ok;
      logic [127:0] d;
      apply_reset();
      base_addr = 16'h0; words_per_row = 16'd8; mem_ready = 1'b1;
      n_checks++;
      if (misaligned !== 1'b0) begin
         n_bad++;
         $display("FAIL mis_before got %b exp 0", misaligned);
      end
      rand_tile(); d = pack_tile(); expect_tile(0, 6); pulse(0, 6, d);
      n_checks++;
      if (misaligned !== 1'b1) begin
         n_bad++;
         $display("FAIL mis_set got %b exp 1", misaligned);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem_addr !== 16'd1) begin
         n_bad++;
         $display("FAIL mis_first_addr got %h exp 0001", mem_addr);
      end
      wait_done(30, ok);
      n_checks++;
      if (!ok || tiles_written !== 16'd1 || misaligned !== 1'b1) begin
         n_bad++;
         $display("FAIL mis_done got ok=%b tiles=%0d mis=%b exp 1/1/1", ok, tiles_written, misaligned);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_misaligned();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
